// File: rtl/mem_pkg.sv
// Shared types for the memory-port arbiter: request record, arbiter states
// and the number of requesters sharing the port.
package mem_pkg;

    localparam int NUM_REQ        = 2;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                      write;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, and on a tie the
// requester that did not win last time gets the grant (one-hot).
module rr_pick2
    import mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the core (requester 0) and the
// loader/debug agent (requester 1); one transaction in flight at a time.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    m_req_valid,
    output logic                    m_req_write,
    output logic [ADDR_WIDTH-1:0]   m_req_addr,
    output logic [DATA_WIDTH-1:0]   m_req_wdata,
    input  logic                    m_req_ready,
    input  logic                    m_resp_valid,
    input  logic [DATA_WIDTH-1:0]   m_resp_rdata
);

    arb_state_t          state;
    logic                owner;
    logic                last_grant;
    logic [NUM_REQ-1:0]  grant;
    logic                win;
    logic                sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign win       = grant[1];
    assign sel_write = req_write[win];
    assign sel_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

    // Ready is gated by reset so nothing looks accepted while the block is held.
    assign req_ready = (reset && state == IDLE) ? grant : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b0;
            m_req_valid <= 1'b0;
            m_req_write <= 1'b0;
            m_req_addr  <= '0;
            m_req_wdata <= '0;
            resp_valid  <= '0;
            resp_rdata  <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        m_req_valid <= 1'b1;
                        m_req_write <= sel_write;
                        m_req_addr  <= sel_addr;
                        m_req_wdata <= sel_wdata;
                        owner       <= win;
                        last_grant  <= win;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_req_ready) begin
                        m_req_valid <= 1'b0;
                        if (m_req_write) begin
                            resp_valid[owner] <= 1'b1;
                            state             <= IDLE;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (m_resp_valid) begin
                        resp_rdata        <= m_resp_rdata;
                        resp_valid[owner] <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed literal values.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_write, req_ready, resp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] resp_rdata, m_req_addr, m_req_wdata, m_resp_rdata;
    logic        m_req_valid, m_req_write, m_req_ready, m_resp_valid;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .m_req_valid  (m_req_valid),
        .m_req_write  (m_req_write),
        .m_req_addr   (m_req_addr),
        .m_req_wdata  (m_req_wdata),
        .m_req_ready  (m_req_ready),
        .m_resp_valid (m_resp_valid),
        .m_resp_rdata (m_resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int i, input logic v, input logic w,
                                  input logic [31:0] a, input logic [31:0] d);
        req_valid[i]         = v;
        req_write[i]         = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    // Transaction-level reference: phase 0 = no transaction, 1 = offered to
    // memory, 2 = waiting for read data.
    mem_req_t    mtxn;
    int          mphase;
    logic        mowner, mlast, mrdata_known;
    logic [1:0]  mresp, mwin, exp_ready;
    logic [31:0] mrdata;

    function automatic logic [1:0] model_winner(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mphase = 0; mtxn = '0; mowner = 1'b0; mlast = 1'b0;
            mresp = 2'b00; mrdata = '0; mrdata_known = 1'b1;
        end else begin
            mresp = 2'b00;
            if (mphase == 0) begin
                mwin = model_winner(req_valid, mlast);
                if (mwin != 2'b00) begin
                    mowner      = mwin[1];
                    mlast       = mwin[1];
                    mtxn.write  = req_write[mowner];
                    mtxn.addr   = mowner ? req_addr[63:32] : req_addr[31:0];
                    mtxn.wdata  = mowner ? req_wdata[63:32] : req_wdata[31:0];
                    mphase      = 1;
                end
            end else if (mphase == 1) begin
                if (m_req_ready) begin
                    if (mtxn.write) begin
                        mresp[mowner] = 1'b1;
                        mrdata_known  = 1'b0;
                        mphase        = 0;
                    end else begin
                        mphase = 2;
                    end
                end
            end else if (m_resp_valid) begin
                mrdata        = m_resp_rdata;
                mrdata_known  = 1'b1;
                mresp[mowner] = 1'b1;
                mphase        = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_ready = (reset && mphase == 0) ? model_winner(req_valid, mlast) : 2'b00;
        check_output("req_ready", req_ready, exp_ready);
        check_output("resp_valid", resp_valid, mresp);
        check_output("m_req_valid", m_req_valid, mphase == 1);
        if (mphase == 1) begin
            check_output("m_req_write", m_req_write, mtxn.write);
            check_output("m_req_addr", m_req_addr, mtxn.addr);
            check_output("m_req_wdata", m_req_wdata, mtxn.wdata);
        end
        if (mrdata_known) check_output("resp_rdata", resp_rdata, mrdata);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog");
    end

    int          rc [2];
    int          gc [2];
    int          grant_log[$];
    int          cyc;
    logic [1:0]  acc;

    initial begin
        reset = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_rdata = '0;

        // Reset held with both requesters asking; requester 1 must win first.
        apply_stimulus(0, 1'b1, 1'b1, 32'h100, 32'hA0);
        apply_stimulus(1, 1'b1, 1'b1, 32'h104, 32'hA1);
        m_req_ready = 1'b1;
        tick(3);
        check_output("rst req_ready", req_ready, 2'b00);
        check_output("rst m_req_valid", m_req_valid, 1'b0);
        check_output("rst m_req_addr", m_req_addr, 32'h0);
        check_output("rst m_req_wdata", m_req_wdata, 32'h0);
        check_output("rst resp_valid", resp_valid, 2'b00);
        check_output("rst resp_rdata", resp_rdata, 32'h0);
        reset = 1'b1;
        tick();
        check_output("first grant addr", m_req_addr, 32'h104);
        check_output("first grant wdata", m_req_wdata, 32'hA1);
        apply_stimulus(1, 1'b0, 1'b1, 32'h104, 32'hA1);
        tick();
        check_output("first resp", resp_valid, 2'b10);
        tick();
        check_output("second grant addr", m_req_addr, 32'h100);
        apply_stimulus(0, 1'b0, 1'b1, 32'h100, 32'hA0);
        tick(3);

        // Single write, memory always ready.
        apply_stimulus(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        apply_stimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        check_output("wr m_req_valid", m_req_valid, 1'b1);
        check_output("wr m_req_addr", m_req_addr, 32'h10);
        check_output("wr m_req_wdata", m_req_wdata, 32'hDEADBEEF);
        check_output("wr m_req_write", m_req_write, 1'b1);
        check_output("wr resp T+1", resp_valid, 2'b00);
        tick();
        check_output("wr resp T+2", resp_valid, 2'b01);
        tick();
        check_output("wr resp T+3", resp_valid, 2'b00);
        tick(2);

        // Read with downstream stall and delayed data.
        m_req_ready = 1'b0;
        apply_stimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        apply_stimulus(1, 1'b0, 1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check_output("stall m_req_addr", m_req_addr, 32'h20);
            check_output("stall m_req_valid", m_req_valid, 1'b1);
            tick();
        end
        m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        check_output("rd m_req_valid drop", m_req_valid, 1'b0);
        tick(2);
        m_resp_valid = 1'b1; m_resp_rdata = 32'h12345678;
        tick();
        m_resp_valid = 1'b0; m_resp_rdata = 32'h0;
        check_output("rd resp_valid", resp_valid, 2'b10);
        check_output("rd resp_rdata", resp_rdata, 32'h12345678);
        tick(2);

        // Spurious memory responses in IDLE and during a write in ISSUE.
        m_resp_valid = 1'b1; m_resp_rdata = 32'hBAD0BAD0;
        tick();
        m_resp_valid = 1'b0;
        check_output("spur idle resp", resp_valid, 2'b00);
        check_output("spur idle rdata", resp_rdata, 32'h12345678);
        apply_stimulus(0, 1'b1, 1'b1, 32'h30, 32'h55);
        tick();
        apply_stimulus(0, 1'b0, 1'b1, 32'h30, 32'h55);
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0;
        check_output("spur issue resp", resp_valid, 2'b00);
        check_output("spur issue rdata", resp_rdata, 32'h12345678);
        m_req_ready = 1'b1;
        tick();
        check_output("spur write resp", resp_valid, 2'b01);
        tick(2);

        // Contention: both keep requesting, six writes each.
        rc[0] = 0; rc[1] = 0; gc[0] = 0; gc[1] = 0; cyc = 0;
        apply_stimulus(0, 1'b1, 1'b1, 32'h1000, 32'hC000);
        apply_stimulus(1, 1'b1, 1'b1, 32'h2000, 32'hC100);
        while ((rc[0] < 6 || rc[1] < 6) && cyc < 200) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            rc[0] += int'(resp_valid[0]);
            rc[1] += int'(resp_valid[1]);
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    grant_log.push_back(i);
                    gc[i]++;
                    apply_stimulus(i, gc[i] < 6, 1'b1, 32'h1000 * (i + 1) + 32'(gc[i] * 4),
                                   32'hC000 + 32'(i * 256 + gc[i]));
                end
            end
        end
        check_output("contention in budget", cyc < 200, 1'b1);
        check_output("contention grants", grant_log.size(), 12);
        for (int k = 0; k < grant_log.size(); k++)
            check_output("contention order", grant_log[k], (k % 2 == 0) ? 1 : 0);
        check_output("contention resp0", rc[0], 6);
        check_output("contention resp1", rc[1], 6);
        tick(2);

        // Reset while waiting for read data.
        apply_stimulus(1, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        apply_stimulus(1, 1'b0, 1'b0, 32'h40, 32'h0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_output("mid rst m_req_valid", m_req_valid, 1'b0);
        check_output("mid rst m_req_addr", m_req_addr, 32'h0);
        check_output("mid rst resp_valid", resp_valid, 2'b00);
        check_output("mid rst resp_rdata", resp_rdata, 32'h0);
        tick(2);
        reset = 1'b1;
        m_resp_valid = 1'b1; m_resp_rdata = 32'hFEED;
        tick();
        m_resp_valid = 1'b0;
        check_output("post rst resp", resp_valid, 2'b00);
        tick(2);
        check_output("post rst resp later", resp_valid, 2'b00);
        apply_stimulus(0, 1'b1, 1'b0, 32'h50, 32'h0);
        tick();
        apply_stimulus(0, 1'b0, 1'b0, 32'h50, 32'h0);
        check_output("post rst m_req_addr", m_req_addr, 32'h50);
        tick();
        m_resp_valid = 1'b1; m_resp_rdata = 32'hCAFEF00D;
        tick();
        m_resp_valid = 1'b0;
        check_output("post rst rd resp", resp_valid, 2'b01);
        check_output("post rst rd rdata", resp_rdata, 32'hCAFEF00D);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
